// File: rtl/md5_padder.sv
// -----------------------------------------------------------------------------
// md5_padder
//   Producer side of the MD5 core's 512-bit block interface. Collects a
//   message byte stream into 64-byte blocks, appends the 0x80 marker, zero
//   fill and the 64-bit little-endian message bit length, and hands each
//   block out with first/last tags so the downstream controller knows when
//   to re-initialise the core, when to chain, and when to read the hash.
//
// Parameters
//   CNT_W       message byte-counter width (bit length = {cnt,3'b000})
//
// Ports
//   clk         clock, all state on rising edge
//   h_rst_n     asynchronous active-low reset
//   in_data     message byte
//   in_valid    in_data valid
//   in_last     final beat of message (with in_valid)
//   in_empty    final beat carries no byte (with in_valid & in_last)
//   in_ready    byte accepted when in_valid & in_ready
//   blk_data    512-bit block, message byte k at blk_data[8k +: 8]
//   blk_valid   block available, held stable until blk_ready
//   blk_ready   consumer takes block when blk_valid & blk_ready
//   blk_first   block is the first of its message
//   blk_last    block is the final padded block of its message
//   busy        message in progress (first beat accepted .. last block taken)
//   ovf         (only with MD5_PAD_OVF_EN) sticky byte-counter wrap flag
//
// Configuration
//   MD5_PAD_OVF_EN  when defined, adds the sticky ovf output; otherwise the
//                   byte counter wraps silently.
// -----------------------------------------------------------------------------
module md5_padder #(
    parameter int CNT_W = 61
) (
    input  logic         clk,
    input  logic         h_rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    input  logic         in_empty,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last,
    output logic         busy
`ifdef MD5_PAD_OVF_EN
    ,
    output logic         ovf
`endif
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2,
        PAD2 = 2'd3
    } state_t;

    state_t             state_reg,  state_next;
    logic [6:0]         pos_reg,    pos_next;    // 0..64, next free byte slot
    logic [CNT_W-1:0]   cnt_reg,    cnt_next;    // message bytes so far
    logic [511:0]       blk_reg,    blk_next;
    logic               last_reg,   last_next;   // tag of block being emitted
    logic               first_reg,  first_next;  // armed until first block taken
    logic               pend2_reg,  pend2_next;  // a length-only block must follow
    logic               mark_reg,   mark_next;   // 0x80 already placed this message
    logic               busy_reg,   busy_next;
`ifdef MD5_PAD_OVF_EN
    logic               ovf_reg,    ovf_next;
`endif

    logic               accept;
    logic               byte_acc;
    logic               len_fits;
    logic [63:0]        len64;
    logic [511:0]       fill_blk;
    logic [511:0]       pad_blk;
    logic [511:0]       pad2_blk;

    assign in_ready  = h_rst_n && (state_reg == FILL);
    assign accept    = in_valid && in_ready;
    // An empty final beat closes the message without contributing a byte.
    assign byte_acc  = accept && !(in_last && in_empty);
    assign len_fits  = (pos_reg <= 7'd55);
    assign len64     = 64'({cnt_reg, 3'b000});

    // Length-only trailer block; carries the 0x80 marker only when the
    // previous block was completely filled with message bytes.
    assign pad2_blk  = {len64, 440'd0, (mark_reg ? 8'h00 : 8'h80)};

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_byte
            localparam logic [6:0] K = 7'(gi);
            logic [7:0] pad_byte;

            assign fill_blk[8*gi +: 8] = (pos_reg == K) ? in_data : blk_reg[8*gi +: 8];

            // Marker at pos, zeros above it, message bytes below it kept.
            assign pad_byte = (pos_reg == K) ? 8'h80 :
                              (pos_reg <  K) ? 8'h00 : blk_reg[8*gi +: 8];

            if (gi < 56) begin : g_body
                assign pad_blk[8*gi +: 8] = pad_byte;
            end else begin : g_len
                assign pad_blk[8*gi +: 8] = len_fits ? len64[8*(gi-56) +: 8] : pad_byte;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge h_rst_n) begin
        if (!h_rst_n) begin
            state_reg <= FILL;
            pos_reg   <= '0;
            cnt_reg   <= '0;
            blk_reg   <= '0;
            last_reg  <= 1'b0;
            first_reg <= 1'b1;
            pend2_reg <= 1'b0;
            mark_reg  <= 1'b0;
            busy_reg  <= 1'b0;
`ifdef MD5_PAD_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            cnt_reg   <= cnt_next;
            blk_reg   <= blk_next;
            last_reg  <= last_next;
            first_reg <= first_next;
            pend2_reg <= pend2_next;
            mark_reg  <= mark_next;
            busy_reg  <= busy_next;
`ifdef MD5_PAD_OVF_EN
            ovf_reg   <= ovf_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        cnt_next   = cnt_reg;
        blk_next   = blk_reg;
        last_next  = last_reg;
        first_next = first_reg;
        pend2_next = pend2_reg;
        mark_next  = mark_reg;
        busy_next  = busy_reg;
`ifdef MD5_PAD_OVF_EN
        ovf_next   = ovf_reg;
`endif

        case (state_reg)
            FILL: begin
                if (accept) begin
                    busy_next = 1'b1;
                    if (byte_acc) begin
                        blk_next = fill_blk;
                        pos_next = pos_reg + 7'd1;
                        cnt_next = cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef MD5_PAD_OVF_EN
                        if (&cnt_reg) begin
                            ovf_next = 1'b1;
                        end
`endif
                    end
                    if (in_last) begin
                        state_next = PAD;
                    end else if (pos_reg == 7'd63) begin
                        last_next  = 1'b0;
                        state_next = EMIT;
                    end
                end
            end

            PAD: begin
                blk_next   = pad_blk;
                state_next = EMIT;
                if (pos_reg == 7'd64) begin
                    // Block is all message bytes; marker and length go next.
                    last_next  = 1'b0;
                    pend2_next = 1'b1;
                    mark_next  = 1'b0;
                end else begin
                    mark_next = 1'b1;
                    if (len_fits) begin
                        last_next = 1'b1;
                    end else begin
                        last_next  = 1'b0;
                        pend2_next = 1'b1;
                    end
                end
            end

            EMIT: begin
                if (blk_ready) begin
                    pos_next = '0;
                    if (pend2_reg) begin
                        pend2_next = 1'b0;
                        state_next = PAD2;
                    end else begin
                        state_next = FILL;
                    end
                    if (last_reg) begin
                        cnt_next   = '0;
                        first_next = 1'b1;
                        busy_next  = 1'b0;
                        mark_next  = 1'b0;
                    end else begin
                        first_next = 1'b0;
                    end
                end
            end

            PAD2: begin
                blk_next   = pad2_blk;
                last_next  = 1'b1;
                state_next = EMIT;
            end

            default: begin
                state_next = FILL;
            end
        endcase
    end

    assign blk_valid = (state_reg == EMIT);
    assign blk_data  = blk_reg;
    assign blk_first = blk_valid && first_reg;
    assign blk_last  = blk_valid && last_reg;
    assign busy      = busy_reg;
`ifdef MD5_PAD_OVF_EN
    assign ovf       = ovf_reg;
`endif

endmodule
